// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART with baud tick, TX/RX FSMs and FIFOs.
// Parametrised width/depth, runtime parity/stop, per-word error flags.
module uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty   = (cnt == '0);
  assign full    = cnt[AW];
  assign dout    = empty ? '0 : mem[rptr];

  // pointers and occupancy; push+pop on full keeps the count
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        cnt <= cnt + 1'b1;
      else if (do_pop && !do_push)
        cnt <= cnt - 1'b1;
    end
  end

  // storage array, contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

module uart_core_param #(
  parameter int DBIT    = 8,
  parameter int FIFO_AW = 4,
  parameter int DVSR_W  = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  output logic              tx_full,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   r_data,
  output logic              r_perr,
  output logic              r_ferr,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              overrun,
  input  logic              clr_err,
  input  logic              rx,
  output logic              tx
);
  localparam logic [3:0] LAST = 4'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  logic [DVSR_W-1:0] bcnt;
  logic              tick;

  assign tick = (bcnt == dvsr);

  // baud tick counter; a shrunken dvsr forces a wrap
  always_ff @(posedge clock) begin
    if (reset)             bcnt <= '0;
    else if (bcnt >= dvsr) bcnt <= '0;
    else                   bcnt <= bcnt + 1'b1;
  end

  state_t          tx_st, tx_st_n;
  logic [4:0]      tx_tc, tx_tc_n;
  logic [3:0]      tx_nb, tx_nb_n;
  logic [DBIT-1:0] tx_sh, tx_sh_n;
  logic            tx_pb, tx_pb_n;
  logic            tx_pen, tx_pen_n;
  logic            tx_s2, tx_s2_n;
  logic            tx_bit, tx_load;
  logic [DBIT-1:0] tx_head;
  logic            tx_empty;

  uart_fifo #(.W(DBIT), .AW(FIFO_AW)) u_txf (
    .clock (clock),
    .reset (reset),
    .push  (wr_uart),
    .pop   (tx_load),
    .din   (w_data),
    .dout  (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  // TX next state; STOP chains straight into the next word
  always_comb begin
    tx_st_n  = tx_st;
    tx_tc_n  = tx_tc;
    tx_nb_n  = tx_nb;
    tx_sh_n  = tx_sh;
    tx_pb_n  = tx_pb;
    tx_pen_n = tx_pen;
    tx_s2_n  = tx_s2;
    tx_bit   = 1'b1;
    tx_load  = 1'b0;
    unique case (tx_st)
      S_IDLE: tx_load = ~tx_empty;
      S_START: begin
        tx_bit = 1'b0;
        if (tick) begin
          tx_tc_n = tx_tc + 1'b1;
          if (tx_tc == 5'd15) begin
            tx_tc_n = '0;
            tx_nb_n = '0;
            tx_st_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        tx_bit = tx_sh[0];
        if (tick) begin
          tx_tc_n = tx_tc + 1'b1;
          if (tx_tc == 5'd15) begin
            tx_tc_n = '0;
            tx_sh_n = tx_sh >> 1;
            tx_nb_n = tx_nb + 1'b1;
            if (tx_nb == LAST)
              tx_st_n = tx_pen ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        tx_bit = tx_pb;
        if (tick) begin
          tx_tc_n = tx_tc + 1'b1;
          if (tx_tc == 5'd15) begin
            tx_tc_n = '0;
            tx_st_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          tx_tc_n = tx_tc + 1'b1;
          if (tx_tc == (tx_s2 ? 5'd31 : 5'd15)) begin
            tx_st_n = S_IDLE;
            tx_load = ~tx_empty;
          end
        end
      end
      default: tx_st_n = S_IDLE;
    endcase
    if (tx_load) begin
      tx_st_n  = S_START;
      tx_tc_n  = '0;
      tx_sh_n  = tx_head;
      tx_pb_n  = ^tx_head ^ (par_mode == 2'b10);
      tx_pen_n = (par_mode == 2'b01) |
                 (par_mode == 2'b10);
      tx_s2_n  = stop2;
    end
  end

  // TX state register; line is driven from the registered state
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_st  <= S_IDLE;
      tx_tc  <= '0;
      tx_nb  <= '0;
      tx_sh  <= '0;
      tx_pb  <= 1'b0;
      tx_pen <= 1'b0;
      tx_s2  <= 1'b0;
      tx     <= 1'b1;
    end else begin
      tx_st  <= tx_st_n;
      tx_tc  <= tx_tc_n;
      tx_nb  <= tx_nb_n;
      tx_sh  <= tx_sh_n;
      tx_pb  <= tx_pb_n;
      tx_pen <= tx_pen_n;
      tx_s2  <= tx_s2_n;
      tx     <= tx_bit;
    end
  end

  logic            rx_q1, rx_q2;
  state_t          rx_st, rx_st_n;
  logic [3:0]      rx_tc, rx_tc_n;
  logic [3:0]      rx_nb, rx_nb_n;
  logic [DBIT-1:0] rx_sh, rx_sh_n;
  logic            rx_pen, rx_pen_n;
  logic            rx_odd, rx_odd_n;
  logic            rx_perr, rx_perr_n;
  logic            rx_push;

  uart_fifo #(.W(DBIT + 2), .AW(FIFO_AW)) u_rxf (
    .clock (clock),
    .reset (reset),
    .push  (rx_push & ~rx_full),
    .pop   (rd_uart),
    .din   ({~rx_q2, rx_perr, rx_sh}),
    .dout  ({r_ferr, r_perr, r_data}),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // RX next state; samples mid-bit on the synchronised line
  always_comb begin
    rx_st_n   = rx_st;
    rx_tc_n   = rx_tc;
    rx_nb_n   = rx_nb;
    rx_sh_n   = rx_sh;
    rx_pen_n  = rx_pen;
    rx_odd_n  = rx_odd;
    rx_perr_n = rx_perr;
    rx_push   = 1'b0;
    unique case (rx_st)
      S_IDLE: begin
        if (!rx_q2) begin
          rx_st_n   = S_START;
          rx_tc_n   = '0;
          rx_perr_n = 1'b0;
          rx_pen_n  = (par_mode == 2'b01) |
                      (par_mode == 2'b10);
          rx_odd_n  = (par_mode == 2'b10);
        end
      end
      S_START: begin
        if (tick) begin
          rx_tc_n = rx_tc + 1'b1;
          if (rx_tc == 4'd7) begin
            rx_tc_n = '0;
            rx_nb_n = '0;
            rx_st_n = rx_q2 ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          rx_tc_n = rx_tc + 1'b1;
          if (rx_tc == 4'd15) begin
            rx_sh_n = {rx_q2, rx_sh[DBIT-1:1]};
            rx_nb_n = rx_nb + 1'b1;
            if (rx_nb == LAST)
              rx_st_n = rx_pen ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          rx_tc_n = rx_tc + 1'b1;
          if (rx_tc == 4'd15) begin
            rx_perr_n = rx_q2 ^ (^rx_sh) ^ rx_odd;
            rx_st_n   = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          rx_tc_n = rx_tc + 1'b1;
          if (rx_tc == 4'd15) begin
            rx_push = 1'b1;
            rx_st_n = S_IDLE;
          end
        end
      end
      default: rx_st_n = S_IDLE;
    endcase
  end

  // RX synchroniser and state register
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_q1   <= 1'b1;
      rx_q2   <= 1'b1;
      rx_st   <= S_IDLE;
      rx_tc   <= '0;
      rx_nb   <= '0;
      rx_sh   <= '0;
      rx_pen  <= 1'b0;
      rx_odd  <= 1'b0;
      rx_perr <= 1'b0;
    end else begin
      rx_q1   <= rx;
      rx_q2   <= rx_q1;
      rx_st   <= rx_st_n;
      rx_tc   <= rx_tc_n;
      rx_nb   <= rx_nb_n;
      rx_sh   <= rx_sh_n;
      rx_pen  <= rx_pen_n;
      rx_odd  <= rx_odd_n;
      rx_perr <= rx_perr_n;
    end
  end

  // sticky overrun; clearing beats a same-cycle drop
  always_ff @(posedge clock) begin
    if (reset || clr_err)       overrun <= 1'b0;
    else if (rx_push && rx_full) overrun <= 1'b1;
  end
endmodule
